ddr3_dll_code_ctrl: RTL and testbench
=====================================

# ddr3_dll_code_ctrl

Sequencing and code-distribution controller sitting on the user side of the DDR3 DLL wrapper. It drives the DLL's power-down and code-update inputs, waits for lock, samples the 8-bit delay code once it is stable, and delivers it to the lane delay logic over a valid/ack handshake. After the first delivery it re-samples the code periodically, on a delay-difference edge or on request, and reports lock-timeout failures.

## Interface
- `PWRUP_WAIT`, 16: cycles `DLL_POWERDOWN_N` is held low after `ENABLE` rises.
- `LOCK_TIMEOUT`, 4096: cycles allowed in WAIT_LOCK before FAIL.
- `SETTLE_CYCLES`, 4: cycles between the `DLL_CODE_UPDATE` pulse and the first code sample.
- `UPDATE_INTERVAL`, 1024: TRACK cycles between periodic re-samples.
- `SYS_CLK` in 1: single clock; all logic on its rising edge.
- `SYS_RESET_N` in 1: reset, asynchronous and active-low.
- `ENABLE` in 1: 1 runs the sequence; 0 powers the DLL down.
- `FORCE_UPDATE` in 1: single-cycle request for an immediate re-sample.
- `DLL_LOCK` in 1: DLL lock, asynchronous to `SYS_CLK`.
- `DLL_DELAY_DIFF` in 1: DLL delay-difference flag, asynchronous.
- `DLL_CODE` in 8: DLL delay code; quasi-static.
- `DLL_POWERDOWN_N` out 1: DLL power-down, active-low.
- `DLL_CODE_UPDATE` out 1: one-cycle code-update strobe.
- `CODE_OUT` out 8: delivered code.
- `CODE_VALID` out 1: `CODE_OUT` offered to the consumer.
- `CODE_ACK` in 1: consumer accepts `CODE_OUT`.
- `READY` out 1: at least one code delivered since lock was last gained.
- `ERROR` out 1: lock timeout.

## Operation
- `DLL_LOCK` and `DLL_DELAY_DIFF` pass through two-flop synchronisers (`lock_s`, `diff_s`). `diff_s` rise is an edge event.
- The `pending` flag is set by `FORCE_UPDATE` or a `diff_s` rise in any state except OFF and FAIL. It is cleared on entry to UPDATE.
- **OFF**: `DLL_POWERDOWN_N`=0. Go to PWRUP when `ENABLE`=1.
- **PWRUP**: hold `DLL_POWERDOWN_N`=0 for `PWRUP_WAIT` cycles, then drive it to 1 and go to WAIT_LOCK with the timeout counter at 0.
- **WAIT_LOCK**: increment the counter each cycle.
  - `lock_s`=1 → UPDATE.
  - Counter reaches `LOCK_TIMEOUT` → FAIL.
- **UPDATE**: `DLL_CODE_UPDATE`=1 for exactly one cycle, then SETTLE.
- **SETTLE**: wait `SETTLE_CYCLES` cycles, then CAPTURE.
- **CAPTURE**: sample `DLL_CODE` on two consecutive cycles.
  - Samples differ → SETTLE.
  - Samples equal and (`READY`=0 or value ≠ `CODE_OUT`) → load `CODE_OUT` and go to PRESENT.
  - Samples equal, `READY`=1 and value = `CODE_OUT` → TRACK, with no handshake.
- **PRESENT**: `CODE_VALID`=1 and `CODE_OUT` held stable until `CODE_ACK`=1. On the ack cycle go to TRACK and set `READY`=1.
- **TRACK**: the interval counter counts down from `UPDATE_INTERVAL`. Go to UPDATE when the counter reaches 0 or when `pending`=1.
- **Lock loss**: `lock_s`=0 in UPDATE, SETTLE, CAPTURE, PRESENT or TRACK → WAIT_LOCK. `READY`=0, `CODE_VALID`=0 (any offer is abandoned), timeout counter restarts.
- **FAIL**: `ERROR`=1, `DLL_POWERDOWN_N`=0. Leaves only when `ENABLE`=0 → OFF, which clears `ERROR`.
- **`ENABLE`=0 in any state** → OFF. `CODE_VALID`, `READY` and `DLL_POWERDOWN_N` go to 0 on the next edge. `CODE_OUT` keeps its last value.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Timing
- Reset values: `DLL_POWERDOWN_N`=0, `DLL_CODE_UPDATE`=0, `CODE_OUT`=8'h00, `CODE_VALID`=0, `READY`=0, `ERROR`=0, state OFF, `pending`=0.
- All outputs are registered.
- `DLL_LOCK` rise → UPDATE strobe: 3 cycles (2 for synchronisation + 1 state transition).
- Strobe → `CODE_VALID`: `SETTLE_CYCLES` + 3 cycles when the code is stable.
- Handshake: a transfer occurs on an edge where `CODE_VALID` and `CODE_ACK` are both 1.
  - `CODE_VALID` drops on the next edge.
  - `CODE_ACK` while `CODE_VALID`=0 is ignored.
  - The consumer may hold `CODE_ACK` high permanently; each offer then lasts exactly 1 cycle.
- Priority when events coincide: `ENABLE`=0, then lock loss, then ack, then `pending`/interval.
- `FORCE_UPDATE` asserted during UPDATE through PRESENT is remembered through `pending` and causes exactly one extra re-sample.

## Structure
- Package `ddr3_dll_ctrl_pkg`: state enum (OFF, PWRUP, WAIT_LOCK, UPDATE, SETTLE, CAPTURE, PRESENT, TRACK, FAIL), `DLL_CODE_W`=8, and the default parameter constants.
- Sub-module `ddr3_sync2`: two-flop synchroniser with async active-low reset to 0. Instantiated twice, for `DLL_LOCK` and `DLL_DELAY_DIFF`.

## Test plan
- **Basic bring-up**: `ENABLE` rises, `DLL_LOCK` rises 100 cycles later, `DLL_CODE`=8'h5A, `CODE_ACK` tied to 1.
  - `DLL_POWERDOWN_N` rises after 16 cycles.
  - One `DLL_CODE_UPDATE` pulse.
  - `CODE_VALID` for 1 cycle with `CODE_OUT`=8'h5A; `READY`=1.
- **Lock timeout**: `DLL_LOCK` held at 0.
  - `ERROR`=1 and `DLL_POWERDOWN_N`=0 after 4096 WAIT_LOCK cycles.
  - `ENABLE`=0 clears `ERROR`.
- **Unstable code**: `DLL_CODE` toggles 8'h10/8'h11 every cycle for 20 cycles, then holds 8'h11. No `CODE_VALID` until the value holds; then `CODE_OUT`=8'h11.
- **Tracking**:
  - Unchanged code at each interval → strobe every ~1031 cycles, no `CODE_VALID`.
  - Code changes to 8'h60 → one offer with 8'h60.
  - `DLL_DELAY_DIFF` pulse → strobe within 5 cycles.
- **Lock loss during PRESENT** with `CODE_ACK`=0: `CODE_VALID` and `READY` drop 3 cycles after `DLL_LOCK` falls. Relock delivers a fresh code.
- **Async reset mid-TRACK**: every output immediately returns to its reset value, with `CODE_OUT`=8'h00.

Source files
------------

// File: rtl/ddr3_dll_ctrl_pkg.sv
// Shared types and default timing constants for the DDR3 DLL code controller.
package ddr3_dll_ctrl_pkg;

   localparam int unsigned DLL_CODE_W          = 8;
   localparam int unsigned DEF_PWRUP_WAIT      = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT    = 4096;
   localparam int unsigned DEF_SETTLE_CYCLES   = 4;
   localparam int unsigned DEF_UPDATE_INTERVAL = 1024;

   typedef enum logic [3:0] {
      StOff,
      StPwrup,
      StWaitLock,
      StUpdate,
      StSettle,
      StCapture,
      StPresent,
      StTrack,
      StFail
   } ctrl_state_e;

endpackage

// File: rtl/ddr3_sync2.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
module ddr3_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/ddr3_dll_code_ctrl.sv
// Sequences DLL power-up and lock, captures a stable delay code and hands it to the
// lane delay logic over a valid/ack handshake, then re-samples it while tracking.
module ddr3_dll_code_ctrl
   import ddr3_dll_ctrl_pkg::*;
#(
   parameter int unsigned PWRUP_WAIT      = DEF_PWRUP_WAIT,
   parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
   parameter int unsigned SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
   parameter int unsigned UPDATE_INTERVAL = DEF_UPDATE_INTERVAL
) (
   input  logic                  SYS_CLK,
   input  logic                  SYS_RESET_N,
   input  logic                  ENABLE,
   input  logic                  FORCE_UPDATE,
   input  logic                  DLL_LOCK,
   input  logic                  DLL_DELAY_DIFF,
   input  logic [DLL_CODE_W-1:0] DLL_CODE,
   output logic                  DLL_POWERDOWN_N,
   output logic                  DLL_CODE_UPDATE,
   output logic [DLL_CODE_W-1:0] CODE_OUT,
   output logic                  CODE_VALID,
   input  logic                  CODE_ACK,
   output logic                  READY,
   output logic                  ERROR
);

   localparam int unsigned PWR_W    = $clog2(PWRUP_WAIT + 1);
   localparam int unsigned LOCK_W   = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned INTV_W   = $clog2(UPDATE_INTERVAL + 1);

   ctrl_state_e           state_q;
   logic [PWR_W-1:0]      pwr_cnt_q;
   logic [LOCK_W-1:0]     lock_cnt_q;
   logic [SETTLE_W-1:0]   settle_cnt_q;
   logic [INTV_W-1:0]     intv_cnt_q;
   logic [DLL_CODE_W-1:0] cap_q;
   logic                  cap_phase_q;
   logic                  pending_q;
   logic                  diff_q;
   logic                  lock_s;
   logic                  diff_s;
   logic                  diff_rise;
   logic                  req;

   ddr3_sync2 u_sync_lock (
      .clk   (SYS_CLK),
      .rst_n (SYS_RESET_N),
      .d     (DLL_LOCK),
      .q     (lock_s)
   );

   ddr3_sync2 u_sync_diff (
      .clk   (SYS_CLK),
      .rst_n (SYS_RESET_N),
      .d     (DLL_DELAY_DIFF),
      .q     (diff_s)
   );

   assign diff_rise = diff_s & ~diff_q;
   assign req       = FORCE_UPDATE | diff_rise;

   always_ff @(posedge SYS_CLK or negedge SYS_RESET_N) begin
      if (!SYS_RESET_N) begin
         state_q         <= StOff;
         pwr_cnt_q       <= '0;
         lock_cnt_q      <= '0;
         settle_cnt_q    <= '0;
         intv_cnt_q      <= '0;
         cap_q           <= '0;
         cap_phase_q     <= 1'b0;
         pending_q       <= 1'b0;
         diff_q          <= 1'b0;
         DLL_POWERDOWN_N <= 1'b0;
         DLL_CODE_UPDATE <= 1'b0;
         CODE_OUT        <= '0;
         CODE_VALID      <= 1'b0;
         READY           <= 1'b0;
         ERROR           <= 1'b0;
      end else begin
         DLL_CODE_UPDATE <= 1'b0;
         diff_q          <= diff_s;
         // Later clears on entry to UPDATE override this set.
         if (req && state_q != StOff && state_q != StFail) begin
            pending_q <= 1'b1;
         end

         if (!ENABLE) begin
            state_q         <= StOff;
            DLL_POWERDOWN_N <= 1'b0;
            CODE_VALID      <= 1'b0;
            READY           <= 1'b0;
            ERROR           <= 1'b0;
            pending_q       <= 1'b0;
         end else if (!lock_s && state_q inside {StUpdate, StSettle, StCapture, StPresent,
                                                 StTrack}) begin
            state_q    <= StWaitLock;
            lock_cnt_q <= '0;
            CODE_VALID <= 1'b0;
            READY      <= 1'b0;
         end else begin
            unique case (state_q)
               StOff: begin
                  state_q   <= StPwrup;
                  pwr_cnt_q <= '0;
               end
               StPwrup: begin
                  if (pwr_cnt_q == PWR_W'(PWRUP_WAIT - 1)) begin
                     state_q         <= StWaitLock;
                     lock_cnt_q      <= '0;
                     DLL_POWERDOWN_N <= 1'b1;
                  end else begin
                     pwr_cnt_q <= pwr_cnt_q + 1'b1;
                  end
               end
               StWaitLock: begin
                  if (lock_s) begin
                     state_q         <= StUpdate;
                     DLL_CODE_UPDATE <= 1'b1;
                     pending_q       <= 1'b0;
                  end else if (lock_cnt_q == LOCK_W'(LOCK_TIMEOUT - 1)) begin
                     state_q         <= StFail;
                     ERROR           <= 1'b1;
                     DLL_POWERDOWN_N <= 1'b0;
                  end else begin
                     lock_cnt_q <= lock_cnt_q + 1'b1;
                  end
               end
               StUpdate: begin
                  state_q      <= StSettle;
                  settle_cnt_q <= '0;
               end
               StSettle: begin
                  if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                     state_q     <= StCapture;
                     cap_phase_q <= 1'b0;
                  end else begin
                     settle_cnt_q <= settle_cnt_q + 1'b1;
                  end
               end
               StCapture: begin
                  if (!cap_phase_q) begin
                     cap_q       <= DLL_CODE;
                     cap_phase_q <= 1'b1;
                  end else if (DLL_CODE != cap_q) begin
                     state_q      <= StSettle;
                     settle_cnt_q <= '0;
                  end else if (!READY || DLL_CODE != CODE_OUT) begin
                     state_q    <= StPresent;
                     CODE_OUT   <= DLL_CODE;
                     CODE_VALID <= 1'b1;
                  end else begin
                     state_q    <= StTrack;
                     intv_cnt_q <= INTV_W'(UPDATE_INTERVAL);
                  end
               end
               StPresent: begin
                  if (CODE_ACK) begin
                     state_q    <= StTrack;
                     intv_cnt_q <= INTV_W'(UPDATE_INTERVAL);
                     CODE_VALID <= 1'b0;
                     READY      <= 1'b1;
                  end
               end
               StTrack: begin
                  if (intv_cnt_q == '0 || pending_q) begin
                     state_q         <= StUpdate;
                     DLL_CODE_UPDATE <= 1'b1;
                     pending_q       <= 1'b0;
                  end else begin
                     intv_cnt_q <= intv_cnt_q - 1'b1;
                  end
               end
               StFail: begin
                  state_q <= StFail;
               end
               default: begin
                  state_q <= StOff;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ddr3_dll_code_ctrl.sv
// Randomised scoreboard bench for the DLL code controller; a monitor pops expected
// codes whenever a new offer appears on CODE_VALID.
module tb_ddr3_dll_code_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       force_update;
   logic       dll_lock;
   logic       dll_diff;
   logic [7:0] dll_code;
   logic       code_ack;
   logic       pdn;
   logic       upd;
   logic [7:0] code_out;
   logic       code_valid;
   logic       ready;
   logic       error;

   int         chk_cnt    = 0;
   int         err_cnt    = 0;
   int         strobe_cnt = 0;
   int         offer_cnt  = 0;
   logic [7:0] exp_q[$];
   logic       model_ready = 1'b0;
   logic [7:0] model_out   = 8'h00;

   always #5 clk = ~clk;

   ddr3_dll_code_ctrl dut (
      .SYS_CLK         (clk),
      .SYS_RESET_N     (rst_n),
      .ENABLE          (enable),
      .FORCE_UPDATE    (force_update),
      .DLL_LOCK        (dll_lock),
      .DLL_DELAY_DIFF  (dll_diff),
      .DLL_CODE        (dll_code),
      .DLL_POWERDOWN_N (pdn),
      .DLL_CODE_UPDATE (upd),
      .CODE_OUT        (code_out),
      .CODE_VALID      (code_valid),
      .CODE_ACK        (code_ack),
      .READY           (ready),
      .ERROR           (error)
   );

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      chk_cnt++;
      if (act < lo || act > hi) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // 0: pdn high, 1: strobe, 2: valid, 3: error, 4: valid low
   task automatic wait_until(input int which, input int budget, output int n);
      bit hit;
      hit = 1'b0;
      n   = 0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         case (which)
            0:       hit = pdn;
            1:       hit = upd;
            2:       hit = code_valid;
            3:       hit = error;
            4:       hit = !code_valid;
            default: hit = 1'b1;
         endcase
      end
      if (!hit) begin
         chk_cnt++;
         err_cnt++;
         $display("FAIL wait_%0d: got no event in %0d cycles, expected event", which, budget);
      end
   endtask

   // Model: a fresh offer happens unless a code is held and the new value equals it.
   function automatic bit expect_code(input logic [7:0] c);
      bit offer;
      offer = !model_ready || c != model_out;
      if (offer) exp_q.push_back(c);
      model_ready = 1'b1;
      model_out   = c;
      return offer;
   endfunction

   task automatic pulse_force();
      @(negedge clk);
      force_update = 1'b1;
      @(negedge clk);
      force_update = 1'b0;
   endtask

   // Monitor: samples 1 time unit after the falling edge.
   logic       prev_valid = 1'b0;
   logic       prev_ack   = 1'b0;
   logic [7:0] prev_out   = 8'h00;
   always begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_ack   = 1'b0;
      end else begin
         if (upd) strobe_cnt++;
         if (code_valid && !prev_valid) begin
            offer_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_offer", 1, 0);
            end else begin
               check("offer_code", code_out, exp_q.pop_front());
            end
         end
         if (prev_valid && code_valid) check("offer_stable", code_out, prev_out);
         if (prev_valid && prev_ack) check("valid_drop_after_xfer", code_valid, 0);
         prev_valid = code_valid;
         prev_ack   = code_ack;
         prev_out   = code_out;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         n;
      int         s0;
      int         o0;
      logic [7:0] c;

      rst_n        = 1'b1;
      enable       = 1'b0;
      force_update = 1'b0;
      dll_lock     = 1'b0;
      dll_diff     = 1'b0;
      dll_code     = 8'h00;
      code_ack     = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_pdn", pdn, 0);
      check("rst_upd", upd, 0);
      check("rst_code_out", code_out, 8'h00);
      check("rst_valid", code_valid, 0);
      check("rst_ready", ready, 0);
      check("rst_error", error, 0);
      rst_n = 1'b1;

      // Bring-up with code 5A, lock 100 cycles after enable.
      dll_code = 8'h5A;
      void'(expect_code(8'h5A));
      @(negedge clk);
      enable = 1'b1;
      wait_until(0, 40, n);
      check_range("pwrup_cycles", n, 16, 17);
      repeat (100 - n) @(negedge clk);
      dll_lock = 1'b1;
      wait_until(1, 10, n);
      check("lock_to_strobe", n, 3);
      wait_until(2, 20, n);
      check("strobe_to_valid", n, 7);
      repeat (3) @(negedge clk);
      check("bringup_ready", ready, 1);
      check("bringup_strobes", strobe_cnt, 1);

      // Unstable code: toggles 10/11 then settles at 11.
      void'(expect_code(8'h11));
      o0 = offer_cnt;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         force_update = (k == 0);
         dll_code     = (k % 2 == 1) ? 8'h11 : 8'h10;
      end
      dll_code = 8'h11;
      wait_until(2, 40, n);
      repeat (3) @(negedge clk);
      check("unstable_offers", offer_cnt - o0, 1);

      // Periodic re-sample with unchanged code.
      o0 = offer_cnt;
      wait_until(1, 1100, n);
      wait_until(1, 1100, n);
      check_range("interval_period", n, 1025, 1040);
      repeat (10) @(negedge clk);
      check("interval_no_offer", offer_cnt - o0, 0);

      // Code change picked up on the next interval.
      void'(expect_code(8'h60));
      dll_code = 8'h60;
      wait_until(2, 1100, n);
      repeat (3) @(negedge clk);
      check("change_drained", exp_q.size(), 0);

      // Delay-difference pulse.
      @(negedge clk);
      dll_diff = 1'b1;
      n = 0;
      while (!upd && n < 10) begin
         @(negedge clk);
         n++;
         if (n == 2) dll_diff = 1'b0;
      end
      dll_diff = 1'b0;
      check_range("diff_to_strobe", n, 1, 5);
      repeat (20) @(negedge clk);

      // Request during re-sample yields exactly one extra re-sample.
      s0 = strobe_cnt;
      pulse_force();
      repeat (2) @(negedge clk);
      force_update = 1'b1;
      @(negedge clk);
      force_update = 1'b0;
      repeat (40) @(negedge clk);
      check("pending_strobes", strobe_cnt - s0, 2);

      // Random codes with random ack delay.
      for (int t = 0; t < 5; t++) begin
         code_ack = 1'b0;
         c = 8'($urandom);
         if (t == 2) c = model_out;
         dll_code = c;
         if (expect_code(c)) begin
            pulse_force();
            wait_until(2, 30, n);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            code_ack = 1'b1;
            repeat (3) @(negedge clk);
         end else begin
            pulse_force();
            repeat (25) @(negedge clk);
         end
         check("trial_drained", exp_q.size(), 0);
      end

      // Lock loss while an offer is pending.
      code_ack = 1'b0;
      c = 8'($urandom);
      if (c == model_out) c = c ^ 8'h01;
      dll_code = c;
      void'(expect_code(c));
      pulse_force();
      wait_until(2, 30, n);
      repeat (4) @(negedge clk);
      check("offer_held", code_valid, 1);
      dll_lock = 1'b0;
      wait_until(4, 10, n);
      check("lockloss_valid_drop", n, 3);
      check("lockloss_ready", ready, 0);
      model_ready = 1'b0;
      c = 8'($urandom) | 8'h01;
      dll_code = c;
      void'(expect_code(c));
      code_ack = 1'b1;
      dll_lock = 1'b1;
      wait_until(2, 60, n);
      repeat (3) @(negedge clk);
      check("relock_ready", ready, 1);

      // Asynchronous reset mid-track.
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_pdn", pdn, 0);
      check("arst_upd", upd, 0);
      check("arst_code_out", code_out, 8'h00);
      check("arst_valid", code_valid, 0);
      check("arst_ready", ready, 0);
      check("arst_error", error, 0);
      @(negedge clk);
      enable      = 1'b0;
      dll_lock    = 1'b0;
      model_ready = 1'b0;
      rst_n       = 1'b1;

      // Lock timeout.
      s0 = strobe_cnt;
      @(negedge clk);
      enable = 1'b1;
      wait_until(0, 40, n);
      wait_until(3, 4200, n);
      check("timeout_cycles", n, 4096);
      check("timeout_pdn", pdn, 0);
      check("timeout_no_strobe", strobe_cnt - s0, 0);
      enable = 1'b0;
      @(negedge clk);
      check("error_cleared", error, 0);

      // Disable after delivery keeps the delivered code.
      c = 8'($urandom) | 8'h01;
      dll_code = c;
      void'(expect_code(c));
      dll_lock = 1'b1;
      enable   = 1'b1;
      wait_until(2, 80, n);
      repeat (3) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("disable_ready", ready, 0);
      check("disable_pdn", pdn, 0);
      check("disable_valid", code_valid, 0);
      check("disable_code_out", code_out, c);

      repeat (2) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
